ones_count_accum: RTL and testbench

Parametrised, clocked successor to the team's 3-input ones-counter. Each accepted WIDTH-bit word is reduced to its ones count and summed across a frame of words delimited by `in_last`. The frame total, the word count and a sticky saturation flag are then presented on a valid/ready output port. A combinational per-word count output is also provided, so existing ones-counter users can migrate without change.

---
 rtl/ones_count_accum.sv | 71 +++++++
 tb/tb_ones_count_accum.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ones_count_accum.sv
// ones_count_accum: per-word ones count summed over in_last-delimited frames, result on valid/ready
module ones_count_accum #(
    parameter int WIDTH     = 8,
    parameter int CW        = $clog2(WIDTH + 1),
    parameter int ACC_WIDTH = 16,
    parameter int WC_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [CW-1:0]        pop_now,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_count,
    output logic [WC_WIDTH-1:0]  out_words,
    output logic                 out_overflow
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t                state, state_n;
    logic [ACC_WIDTH-1:0] acc, acc_sat;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [WC_WIDTH-1:0]  wc, wc_sat;
    logic [WC_WIDTH:0]    wc_sum;
    logic                 ovf, ovf_n, accept, take;
    assign out_valid = state == HOLD;
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign acc_sum   = {1'b0, acc} + (ACC_WIDTH + 1)'(pop_now);
    assign wc_sum    = {1'b0, wc} + (WC_WIDTH + 1)'(1);
    assign acc_sat   = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
    assign wc_sat    = wc_sum[WC_WIDTH] ? '1 : wc_sum[WC_WIDTH-1:0];
    assign ovf_n     = ovf | acc_sum[ACC_WIDTH] | wc_sum[WC_WIDTH];
    // ones count of the current input word, independent of handshake
    always_comb begin
        pop_now = '0;
        for (int i = 0; i < WIDTH; i++) pop_now = pop_now + CW'(in_data[i]);
    end
    // a last word always lands in HOLD, even when it arrives as the previous result is taken
    always_comb begin
        state_n = (accept && in_last) ? HOLD : take ? ACCUM : state;
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_n;
    end
    // frame accumulators and held result; acc/wc are already zero while holding
    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            wc           <= '0;
            ovf          <= 1'b0;
            out_count    <= '0;
            out_words    <= '0;
            out_overflow <= 1'b0;
        end else if (accept) begin
            acc <= in_last ? '0 : acc_sat;
            wc  <= in_last ? '0 : wc_sat;
            ovf <= in_last ? 1'b0 : ovf_n;
            if (in_last) begin
                out_count    <= acc_sat;
                out_words    <= wc_sat;
                out_overflow <= ovf_n;
            end
        end
    end
endmodule

// File: tb/tb_ones_count_accum.sv
// tb_ones_count_accum: directed checks of pop count, framing, backpressure, saturation and reset
module tb_ones_count_accum;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [3:0] pop_now;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_count;
    logic [7:0] out_words;
    logic       out_overflow;
    logic [2:0] d3 = '0;
    logic       r3;
    logic [1:0] p3;
    logic       v3;
    logic [15:0] c3;
    logic [7:0] w3;
    logic       o3;
    int n_chk = 0;
    int n_pass = 0;
    int exp3[8] = '{0, 1, 1, 2, 1, 2, 2, 3};

    ones_count_accum #(.WIDTH(8), .ACC_WIDTH(8), .WC_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .pop_now(pop_now), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_words(out_words), .out_overflow(out_overflow)
    );

    ones_count_accum #(.WIDTH(3)) legacy (
        .clk(clk), .rst(rst), .in_valid(1'b0), .in_data(d3), .in_last(1'b0),
        .in_ready(r3), .pop_now(p3), .out_valid(v3), .out_ready(1'b0),
        .out_count(c3), .out_words(w3), .out_overflow(o3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic result(input string tag, input int cnt, input int words, input int ovf);
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_count"}, 32'(out_count), 32'(cnt));
        check({tag, "_words"}, 32'(out_words), 32'(words));
        check({tag, "_ovf"}, 32'(out_overflow), 32'(ovf));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            d3 = 3'(i);
            #1;
            check("pop3", 32'(p3), 32'(exp3[i]));
        end
        in_data = 8'hAA;
        #1;
        check("pop8", 32'(pop_now), 4);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_count", 32'(out_count), 0);
        check("rst_words", 32'(out_words), 0);
        check("rst_ovf", 32'(out_overflow), 0);
        check("rst_ready", 32'(in_ready), 1);

        out_ready = 1'b1;
        send(8'h0F, 1'b0);
        send(8'hFF, 1'b0);
        check("mid_valid", 32'(out_valid), 0);
        send(8'h01, 1'b1);
        result("frame", 13, 3, 0);
        @(posedge clk);
        #1;
        check("frame_drop", 32'(out_valid), 0);

        out_ready = 1'b0;
        send(8'h0F, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h01, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", 32'(in_ready), 0);
            result("bp", 13, 3, 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 0);

        for (int i = 0; i < 32; i++) send(8'hFF, 1'b0);
        send(8'hFF, 1'b1);
        result("sat", 255, 33, 1);
        send(8'h03, 1'b1);
        result("post_sat", 2, 1, 0);

        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 8'hAA;
        check("b2b_ready0", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        result("b2b_aa", 4, 1, 0);
        check("b2b_ready1", 32'(in_ready), 1);
        in_data = 8'h80;
        @(posedge clk);
        #1;
        result("b2b_80", 1, 1, 0);
        in_data = 8'h00;
        @(posedge clk);
        #1;
        result("b2b_00", 0, 1, 0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_idle", 32'(out_valid), 0);

        send(8'h0F, 1'b0);
        send(8'hF0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h07, 1'b1);
        result("rst_mid", 3, 1, 0);
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_hold_valid", 32'(out_valid), 0);
        check("rst_hold_count", 32'(out_count), 0);
        check("rst_hold_ready", 32'(in_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
